pipelined_addsub: RTL and testbench
===================================

PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

Interface
Parameters (name, default, meaning):
REQ-001 SHALL provide parameter WIDTH, 16, operand/result width in bits (>=2).
REQ-002 SHALL provide parameter SEG, 4, ripple segment width in bits; WIDTH SHALL be an integer multiple of SEG, and any other value SHALL fail elaboration.
REQ-003 SHALL derive STAGES = WIDTH/SEG as the pipeline depth.

Ports (name, direction, width, meaning):
REQ-004 SHALL have clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have in_valid, input, 1, operands presented.
REQ-007 SHALL have in_ready, output, 1, block accepts operands this cycle.
REQ-008 SHALL have a, input, WIDTH, operand A.
REQ-009 SHALL have b, input, WIDTH, operand B.
REQ-010 SHALL have cin, input, 1, carry-in (add) or borrow-in (subtract).
REQ-011 SHALL have sub, input, 1, 0 = add, 1 = subtract.
REQ-012 SHALL have out_valid, output, 1, result valid.
REQ-013 SHALL have out_ready, input, 1, downstream accepts result.
REQ-014 SHALL have sum, output, WIDTH, result.
REQ-015 SHALL have cout, output, 1, carry out of the MSB.
REQ-016 SHALL have ovf, output, 1, two's-complement signed overflow.

Function
REQ-017 SHALL compute, modulo 2^(WIDTH+1), {cout,sum} = a + b + cin when sub=0, and {cout,sum} = a + ~b + ~cin when sub=1 (that is, a - b - cin; cout=1 means no borrow).
REQ-018 SHALL set ovf = carry into the MSB XOR carry out of the MSB.
REQ-019 SHALL split the addition into STAGES SEG-bit ripple segments, with segment k computed in pipeline stage k and its carry registered into stage k+1; no combinational carry path SHALL span more than SEG bits.
REQ-020 SHALL delay the upper operand segments (input skew) and the completed lower result segments (output deskew) so that sum, cout, ovf and out_valid are aligned at the output.
REQ-021 SHALL use advance enable en = !out_valid | out_ready, and drive in_ready = en.
REQ-022 SHALL load a transfer, when in_valid & in_ready, into stage 1; when en=1 every stage SHALL shift its payload and valid bit forward, and when en=0 all stages SHALL hold.
REQ-023 SHALL present a result accepted at cycle t with out_valid=1 at cycle t+STAGES when en stays 1 (latency STAGES), and SHALL sustain throughput of one result per cycle.
REQ-024 SHALL propagate empty slots (bubbles) as valid=0 and SHALL never create, duplicate or drop a transfer.
REQ-025 SHALL keep sum, cout and ovf stable while out_valid=1 and out_ready=0.
REQ-026 SHALL, when a result is taken (out_ready=1) and a new transfer is accepted in the same cycle, complete both in that cycle.
REQ-027 SHALL capture sub and cin per transfer, so that back-to-back add and subtract transfers each produce their own correct result.

Reset
REQ-028 SHALL, when rst=1 at a clock edge, clear all stage valid bits and drive out_valid=0, sum=0, cout=0 and ovf=0 after that edge.
REQ-029 SHALL discard in-flight transfers on reset mid-operation, and SHALL ignore in_valid during any cycle with rst=1.
REQ-030 SHALL hold in_ready=1 in the cycle after reset is released.

Verification (WIDTH=16, SEG=4)
REQ-031 SHALL cover: a=0x0002, b=0x0006, cin=0, sub=0, out_ready=1 -> sum=0x0008, cout=0, ovf=0, out_valid exactly 4 cycles after acceptance.
REQ-032 SHALL cover: a=0xFFFF, b=0x0001, add -> sum=0x0000, cout=1, ovf=0; and a=0x7FFF, b=0x0001, add -> sum=0x8000, cout=0, ovf=1.
REQ-033 SHALL cover: a=0x0005, b=0x0007, cin=0, sub=1 -> sum=0xFFFE, cout=0, ovf=0; followed back-to-back by a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
REQ-034 SHALL cover: 8 consecutive transfers with out_ready=0 for 3 cycles mid-stream -> in_ready=0 while stalled, outputs held, all 8 results emitted in order with none lost.
REQ-035 SHALL cover: rst asserted 2 cycles after a transfer is accepted -> out_valid never asserts for that transfer, outputs are 0, and the next transfer after reset completes correctly.

Source files
------------

// File: rtl/pipelined_addsub_if.sv
// Operand/result bus of the pipelined adder/subtractor.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both 1. While valid=1 and ready=0 the source holds valid and its
// payload stable. Ready may depend on the other side's valid, but valid
// never depends on ready.
interface pipelined_addsub_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   // Side that feeds operands and takes results.
   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   // The arithmetic block itself.
   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined ripple adder/subtractor. The WIDTH-bit operation is cut into
// STAGES = WIDTH/SEG segments of SEG bits. Segment k is added in stage k and
// its carry is registered into stage k+1. Each stage carries only the operand
// bits still to be added (input skew) and the result bits already finished
// (output deskew), so the last stage holds the complete aligned result.
// A subtraction is done as a + ~b + ~cin, so cout=1 means "no borrow".
// Empty slots travel with all-zero payload, so sum/cout/ovf read 0 whenever
// out_valid is 0.
module pipelined_addsub #(
   parameter int WIDTH = 16,
   parameter int SEG   = 4
) (
   input logic               clk,
   input logic               rst,
   pipelined_addsub_if.slave bus
);

   localparam int STAGES = WIDTH / SEG;

   if (SEG < 1 || WIDTH < 2 || (WIDTH % SEG) != 0) begin : g_bad_params
      $error("pipelined_addsub: WIDTH must be >= 2 and a multiple of SEG");
   end

   logic             en;
   logic             load;
   logic [WIDTH-1:0] b_eff;
   logic             c_in0;

   // Global advance enable; operands are conditioned for subtraction once, at entry.
   always_comb begin
      en    = !bus.out_valid || bus.out_ready;
      load  = bus.in_valid && en;
      b_eff = bus.sub ? ~bus.b : bus.b;
      c_in0 = bus.sub ? ~bus.cin : bus.cin;
   end

   assign bus.in_ready = en;

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam int DW = (k + 1) * SEG;   // result bits complete after this stage
      localparam int RW = WIDTH - DW;      // operand bits still to be added

      logic           v;
      logic           cy;
      logic [DW-1:0]  res;
      logic           v_in;
      logic [SEG-1:0] seg_a;
      logic [SEG-1:0] seg_b;
      logic           seg_ci;
      logic [SEG:0]   seg_sum;
      logic [DW-1:0]  res_nxt;

      if (k == 0) begin : g_src
         // First segment straight from the bus; a bubble enters as zeros.
         always_comb begin
            v_in    = load;
            seg_a   = load ? bus.a[SEG-1:0] : '0;
            seg_b   = load ? b_eff[SEG-1:0] : '0;
            seg_ci  = load & c_in0;
            seg_sum = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG{1'b0}}, seg_ci};
            res_nxt = seg_sum[SEG-1:0];
         end
      end else begin : g_src
         // Next segment from the skewed operands and the registered carry of the previous stage.
         always_comb begin
            v_in    = g_stg[k-1].v;
            seg_a   = g_stg[k-1].g_ops.opa[SEG-1:0];
            seg_b   = g_stg[k-1].g_ops.opb[SEG-1:0];
            seg_ci  = g_stg[k-1].cy;
            seg_sum = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG{1'b0}}, seg_ci};
            res_nxt = {seg_sum[SEG-1:0], g_stg[k-1].res};
         end
      end

      // Stage register: valid, carry out of this segment and the finished low result bits.
      always_ff @(posedge clk) begin
         if (rst) begin
            v   <= 1'b0;
            cy  <= 1'b0;
            res <= '0;
         end else if (en) begin
            v   <= v_in;
            cy  <= seg_sum[SEG];
            res <= res_nxt;
         end
      end

      if (RW > 0) begin : g_ops
         logic [RW-1:0] opa;
         logic [RW-1:0] opb;
         logic [RW-1:0] opa_nxt;
         logic [RW-1:0] opb_nxt;

         if (k == 0) begin : g_first
            // Upper operand segments captured at acceptance, zeroed for a bubble.
            always_comb begin
               opa_nxt = load ? bus.a[WIDTH-1:SEG] : '0;
               opb_nxt = load ? b_eff[WIDTH-1:SEG] : '0;
            end
         end else begin : g_next
            // Drop the segment consumed by this stage, keep the rest.
            always_comb begin
               opa_nxt = g_stg[k-1].g_ops.opa[RW+SEG-1:SEG];
               opb_nxt = g_stg[k-1].g_ops.opb[RW+SEG-1:SEG];
            end
         end

         // Skew register for the operand bits that later stages still need.
         always_ff @(posedge clk) begin
            if (rst) begin
               opa <= '0;
               opb <= '0;
            end else if (en) begin
               opa <= opa_nxt;
               opb <= opb_nxt;
            end
         end
      end

      if (k == STAGES - 1) begin : g_last
         logic ovf_r;
         logic ovf_nxt;

         // Carry into the MSB is recovered from the MSB sum bit; overflow is it XOR carry out.
         always_comb begin
            ovf_nxt = (seg_a[SEG-1] ^ seg_b[SEG-1] ^ seg_sum[SEG-1]) ^ seg_sum[SEG];
         end

         // Overflow flag travels with the final segment.
         always_ff @(posedge clk) begin
            if (rst) begin
               ovf_r <= 1'b0;
            end else if (en) begin
               ovf_r <= ovf_nxt;
            end
         end
      end
   end

   assign bus.out_valid = g_stg[STAGES-1].v;
   assign bus.sum       = g_stg[STAGES-1].res;
   assign bus.cout      = g_stg[STAGES-1].cy;
   assign bus.ovf       = g_stg[STAGES-1].g_last.ovf_r;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub (WIDTH=16, SEG=4): directed vectors, a
// scoreboard fed by an arithmetic model, and literal result checks.
module tb_pipelined_addsub;
   localparam int W   = 16;
   localparam int S   = 4;
   localparam int LAT = W / S;

   logic         clk;
   logic         rst;
   int           cyc      = 0;
   int           n_checks = 0;
   int           n_fail   = 0;
   int           n_pop    = 0;
   int           last_acc = 0;
   logic [W+1:0] exp_q[$];

   pipelined_addsub_if #(.WIDTH(W)) bus ();

   pipelined_addsub #(.WIDTH(W), .SEG(S)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, required end of test before it");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   // ---------------- model: {cout, ovf, sum} from plain integer arithmetic ----------------
   function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                          input logic mc, input logic ms);
      int ua, ub, sa, sb, c, ur, sr;
      logic co, ov;
      logic [W-1:0] s;
      ua = int'(ma);
      ub = int'(mb);
      sa = int'($signed(ma));
      sb = int'($signed(mb));
      c  = mc ? 1 : 0;
      if (!ms) begin
         ur = ua + ub + c;
         sr = sa + sb + c;
         co = (ur >= (1 << W));
      end else begin
         ur = ua - ub - c;
         sr = sa - sb - c;
         co = (ur >= 0);
      end
      s  = ur[W-1:0];
      ov = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
      return {co, ov, s};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                       input logic tc, input logic ts);
      int   g;
      logic ok;
      g  = 0;
      ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.a        = ta;
      bus.b        = tbv;
      bus.cin      = tc;
      bus.sub      = ts;
      while (!ok && g < 100) begin
         @(negedge clk);
         ok = bus.in_ready && !rst;
         g++;
      end
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: in_ready 0 for %0d cycles, required 1", g);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   // Waits for the next result handed over; returns it and its latency from the last acceptance.
   task automatic wait_out(output logic [W+1:0] r, output int lat);
      int g;
      g   = 0;
      r   = '0;
      lat = -1;
      while (g < 50) begin
         @(negedge clk);
         g++;
         if (bus.out_valid && bus.out_ready) begin
            r   = {bus.cout, bus.ovf, bus.sum};
            lat = cyc - last_acc;
            @(posedge clk);
            #1;
            return;
         end
      end
      n_checks++;
      n_fail++;
      $display("FAIL out_timeout: out_valid 0 for %0d cycles, required 1", g);
      @(posedge clk);
      #1;
   endtask

   // ---------------- scoreboard / compare process ----------------
   logic         rst_seen = 1'b0;
   logic         hold_act = 1'b0;
   logic [W+1:0] hold_val = '0;
   logic [W+1:0] got;
   logic [W+1:0] want;

   always @(negedge clk) begin
      got = {bus.cout, bus.ovf, bus.sum};
      if (rst) begin
         exp_q.delete();
         hold_act = 1'b0;
         rst_seen = 1'b1;
      end else begin
         if (rst_seen) begin
            check("reset_out_valid", 32'(bus.out_valid), 32'(0));
            check("reset_outputs", 32'(got), 32'(0));
            check("reset_in_ready", 32'(bus.in_ready), 32'(1));
            rst_seen = 1'b0;
         end
         check("in_ready_rule", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
         if (hold_act) begin
            check("stall_hold_valid", 32'(bus.out_valid), 32'(1));
            check("stall_hold_data", 32'(got), 32'(hold_val));
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_output: actual 0x%0h, required no result", got);
            end else begin
               want = exp_q.pop_front();
               check("scoreboard", 32'(got), 32'(want));
               n_pop++;
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
            last_acc = cyc;
         end
         hold_act = bus.out_valid && !bus.out_ready;
         hold_val = got;
      end
   end

   // ---------------- stimulus ----------------
   logic [W-1:0] va[8] = '{16'h1234, 16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF, 16'h1000, 16'hABCD, 16'h0001};
   logic [W-1:0] vb[8] = '{16'h1111, 16'hFFFF, 16'h0001, 16'h8000, 16'h7FFF, 16'h0FFF, 16'h1234, 16'h0001};
   logic         vc[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
   logic         vs[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

   initial begin
      logic [W+1:0] r;
      int           lat;
      int           pop0;

      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
      bus.sub       = 1'b0;
      bus.out_ready = 1'b1;

      // Pin the model with hand-computed results ({cout, ovf, sum}).
      check("model_2p6", 32'(model(16'h0002, 16'h0006, 1'b0, 1'b0)), 32'h00008);
      check("model_ffffp1", 32'(model(16'hFFFF, 16'h0001, 1'b0, 1'b0)), 32'h20000);
      check("model_7fffp1", 32'(model(16'h7FFF, 16'h0001, 1'b0, 1'b0)), 32'h18000);
      check("model_5m7", 32'(model(16'h0005, 16'h0007, 1'b0, 1'b1)), 32'h0FFFE);
      check("model_8000m1", 32'(model(16'h8000, 16'h0001, 1'b0, 1'b1)), 32'h37FFF);

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Simple add with latency.
      send(16'h0002, 16'h0006, 1'b0, 1'b0);
      wait_out(r, lat);
      check("add_2p6", 32'(r), 32'h00008);
      check("latency", 32'(lat), 32'(LAT));

      // Carry out and signed overflow, back to back.
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      wait_out(r, lat);
      check("add_ffffp1", 32'(r), 32'h20000);
      wait_out(r, lat);
      check("add_7fffp1", 32'(r), 32'h18000);
      check("b2b_latency", 32'(lat), 32'(LAT));

      // Subtraction with borrow, then with overflow, back to back.
      send(16'h0005, 16'h0007, 1'b0, 1'b1);
      send(16'h8000, 16'h0001, 1'b0, 1'b1);
      wait_out(r, lat);
      check("sub_5m7", 32'(r), 32'h0FFFE);
      wait_out(r, lat);
      check("sub_8000m1", 32'(r), 32'h37FFF);

      // Eight transfers with a 3-cycle downstream stall mid-stream.
      pop0 = n_pop;
      fork
         begin
            for (int i = 0; i < 8; i++) send(va[i], vb[i], vc[i], vs[i]);
         end
         begin
            repeat (5) @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               check("stall_in_ready", 32'(bus.in_ready), 32'(0));
               check("stall_out_valid", 32'(bus.out_valid), 32'(1));
            end
            @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      repeat (20) @(posedge clk);
      #1;
      check("stream_count", 32'(n_pop - pop0), 32'(8));
      check("stream_drained", 32'(exp_q.size()), 32'(0));

      // Reset two cycles after acceptance discards the transfer; in_valid during reset is ignored.
      send(16'h0003, 16'h0004, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.a        = 16'hFFFF;
      bus.b        = 16'hFFFF;
      @(posedge clk);
      #1;
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      repeat (8) begin
         @(negedge clk);
         check("rst_discard_valid", 32'(bus.out_valid), 32'(0));
         check("rst_discard_data", 32'({bus.cout, bus.ovf, bus.sum}), 32'(0));
      end
      @(posedge clk);
      #1;
      send(16'h1234, 16'h0034, 1'b1, 1'b1);
      wait_out(r, lat);
      check("after_reset_sub", 32'(r), 32'h211FF);
      check("after_reset_latency", 32'(lat), 32'(LAT));

      repeat (10) @(posedge clk);
      check("final_drained", 32'(exp_q.size()), 32'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
